shift_deser: RTL and testbench

SHIFT_DESER -- requirements
Module: shift_deser

---
 rtl/shift_deser_pkg.sv | 12 +
 rtl/shift_deser_obuf.sv | 42 ++++
 rtl/shift_deser.sv | 92 +++++++++
 tb/tb_shift_deser.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserialiser.
package shift_deser_pkg;
  localparam int WIDTH_DEF = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;
endpackage

// File: rtl/shift_deser_obuf.sv
// Single-entry valid/ready holding register for completed words.
// Handshake: a transfer happens on any clk edge with pout_vld=1 and pout_rdy=1;
// pout is stable while pout_vld=1 and holds its last value after a transfer.
module shift_deser_obuf
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_vld,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] pout,
  output logic             pout_vld,
  input  logic             pout_rdy,
  output logic             ovr
);

  logic xfer;
  logic can_load;

  assign xfer     = pout_vld && pout_rdy;
  assign can_load = !pout_vld || pout_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pout     <= '0;
      pout_vld <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      // A stuck consumer drops the new word; the held word is never overwritten.
      ovr <= word_vld && !can_load;
      if (word_vld && can_load) begin
        pout     <= word;
        pout_vld <= 1'b1;
      end else if (xfer) begin
        pout_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_deser.sv
// Strobed serial receiver: start bit, WIDTH data bits (LSB- or MSB-first), stop bit.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             mode,
  output logic [WIDTH-1:0] pout,
  output logic             pout_vld,
  input  logic             pout_rdy,
  output logic             frm_err,
  output logic             ovr,
  output logic             busy,
  output state_t           state
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             mode_q, mode_nxt;
  logic             word_done;
  logic             frm_err_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      mode_q  <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      mode_q  <= mode_nxt;
      frm_err <= frm_err_nxt;
    end
  end

  // Nothing advances without a strobe, so arbitrary gaps between bits are safe.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    mode_nxt    = mode_q;
    word_done   = 1'b0;
    frm_err_nxt = 1'b0;
    if (sin_en) begin
      case (state)
        IDLE: begin
          if (sin == START_BIT) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            shreg_nxt = '0;
            mode_nxt  = mode;
          end
        end
        DATA: begin
          shreg_nxt = mode_q ? {shreg[WIDTH-2:0], sin} : {sin, shreg[WIDTH-1:1]};
          cnt_nxt   = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (sin == STOP_BIT) word_done = 1'b1;
          else frm_err_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  shift_deser_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .word_vld (word_done),
    .word     (shreg),
    .pout     (pout),
    .pout_vld (pout_vld),
    .pout_rdy (pout_rdy),
    .ovr      (ovr)
  );

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser: frame formats, errors, overrun, reset, back-to-back.
module tb_shift_deser;
  import shift_deser_pkg::*;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic       mode;
  logic [7:0] pout;
  logic       pout_vld;
  logic       pout_rdy;
  logic       frm_err;
  logic       ovr;
  logic       busy;
  state_t     state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       mon_en  = 1'b0;
  logic       err_seen = 1'b0;

  shift_deser #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sin      (sin),
    .sin_en   (sin_en),
    .mode     (mode),
    .pout     (pout),
    .pout_vld (pout_vld),
    .pout_rdy (pout_rdy),
    .frm_err  (frm_err),
    .ovr      (ovr),
    .busy     (busy),
    .state    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_bit(input logic b, input logic r);
    @(negedge clk);
    sin      = b;
    sin_en   = 1'b1;
    pout_rdy = r;
    @(posedge clk);
    #1;
    sin_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic idle_cyc(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pout_rdy = r;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic m, input logic stop_b,
                            input logic r_data, input logic r_stop);
    @(negedge clk);
    mode = m;
    send_bit(1'b0, r_data);
    for (int i = 0; i < 8; i++) send_bit(m ? d[7-i] : d[i], r_data);
    send_bit(stop_b, r_stop);
  endtask

  // scoreboard: transfers must match the expected queue in order
  always @(posedge clk) begin
    if (mon_en) begin
      if (frm_err || ovr) err_seen <= 1'b1;
      if (pout_vld && pout_rdy) begin
        if (exp_q.size() == 0) chk("xfer_unexpected", {8'h0, pout}, 16'hFFFF);
        else chk("xfer_order", {8'h0, pout}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [9:0] seq;
    logic [7:0] msb_bits;

    rst      = 1'b0;
    sin      = 1'b1;
    sin_en   = 1'b0;
    mode     = 1'b0;
    pout_rdy = 1'b0;
    #12;
    chk("rst_pout", {8'h0, pout}, 16'h0000);
    chk("rst_vld", {15'h0, pout_vld}, 16'h0);
    chk("rst_frm_err", {15'h0, frm_err}, 16'h0);
    chk("rst_ovr", {15'h0, ovr}, 16'h0);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_state", 16'(state), 16'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    idle_cyc(2, 1'b0);
    chk("idle_state", 16'(state), 16'(IDLE));

    // LSB-first frame from an explicit strobe list
    seq = 10'b0010110001;
    for (int i = 9; i >= 0; i--) begin
      send_bit(seq[i], 1'b0);
      if (i == 8) chk("lsb_busy", {15'h0, busy}, 16'h1);
    end
    chk("lsb_pout", {8'h0, pout}, 16'h001A);
    chk("lsb_vld", {15'h0, pout_vld}, 16'h1);
    chk("lsb_frm_err", {15'h0, frm_err}, 16'h0);
    chk("lsb_busy_end", {15'h0, busy}, 16'h0);
    idle_cyc(1, 1'b1);
    chk("drain_vld", {15'h0, pout_vld}, 16'h0);
    chk("drain_hold", {8'h0, pout}, 16'h001A);
    idle_cyc(1, 1'b0);

    // MSB-first with random gaps and mode toggled mid-frame
    @(negedge clk);
    mode = 1'b1;
    send_bit(1'b0, 1'b0);
    msb_bits = 8'b0011_1100;
    for (int i = 0; i < 8; i++) begin
      idle_cyc($urandom_range(0, 4), 1'b0);
      if (i == 3) mode = 1'b0;
      send_bit(msb_bits[7-i], 1'b0);
    end
    idle_cyc($urandom_range(1, 3), 1'b0);
    chk("msb_state_stop", 16'(state), 16'(STOP));
    mode = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("msb_pout", {8'h0, pout}, 16'h003C);
    chk("msb_vld", {15'h0, pout_vld}, 16'h1);
    idle_cyc(1, 1'b1);
    idle_cyc(1, 1'b0);

    // framing error
    send_frame(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ferr_pulse", {15'h0, frm_err}, 16'h1);
    chk("ferr_vld", {15'h0, pout_vld}, 16'h0);
    chk("ferr_state", 16'(state), 16'(IDLE));
    chk("ferr_ovr", {15'h0, ovr}, 16'h0);
    idle_cyc(1, 1'b0);
    chk("ferr_one_cycle", {15'h0, frm_err}, 16'h0);

    // overrun with a stalled consumer
    send_frame(8'h2B, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_first", {8'h0, pout}, 16'h002B);
    send_frame(8'h18, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_pulse", {15'h0, ovr}, 16'h1);
    chk("ovr_keep", {8'h0, pout}, 16'h002B);
    chk("ovr_vld", {15'h0, pout_vld}, 16'h1);
    chk("ovr_no_ferr", {15'h0, frm_err}, 16'h0);
    idle_cyc(1, 1'b0);
    chk("ovr_one_cycle", {15'h0, ovr}, 16'h0);
    idle_cyc(1, 1'b1);
    chk("ovr_drain", {15'h0, pout_vld}, 16'h0);

    // same pair, consumer ready exactly on the second stop edge
    send_frame(8'h2B, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h18, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rdy_stop_pout", {8'h0, pout}, 16'h0018);
    chk("rdy_stop_vld", {15'h0, pout_vld}, 16'h1);
    chk("rdy_stop_ovr", {15'h0, ovr}, 16'h0);
    idle_cyc(1, 1'b0);
    chk("rdy_stop_ovr2", {15'h0, ovr}, 16'h0);

    // asynchronous reset after four data bits
    @(negedge clk);
    mode = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_pout", {8'h0, pout}, 16'h0000);
    chk("mid_rst_vld", {15'h0, pout_vld}, 16'h0);
    chk("mid_rst_busy", {15'h0, busy}, 16'h0);
    chk("mid_rst_state", 16'(state), 16'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    idle_cyc(1, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_pout", {8'h0, pout}, 16'h0029);
    chk("post_rst_vld", {15'h0, pout_vld}, 16'h1);

    // back-to-back frames with an always-ready consumer
    idle_cyc(1, 1'b1);
    chk("b2b_pre_drain", {15'h0, pout_vld}, 16'h0);
    exp_q.push_back(8'h2F);
    exp_q.push_back(8'h19);
    mon_en = 1'b1;
    send_frame(8'h2F, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("b2b_first", {8'h0, pout}, 16'h002F);
    send_frame(8'h19, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("b2b_second", {8'h0, pout}, 16'h0019);
    idle_cyc(2, 1'b1);
    mon_en = 1'b0;
    chk("b2b_all_xfers", 16'(exp_q.size()), 16'h0);
    chk("b2b_no_errors", {15'h0, err_seen}, 16'h0);
    chk("b2b_vld_clear", {15'h0, pout_vld}, 16'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
